// File: rtl/axi_m2s_pkg.sv
// Shared AXI constants and FSM encoding for the write-burst traffic generator.
package axi_m2s_pkg;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } wr_state_e;

endpackage

// File: rtl/axi_m2s_wr_gen.sv
// AXI4 write-burst generator: NUM_BURSTS INCR bursts of incrementing data per start,
// one burst outstanding, AW then W then B strictly in sequence.
module axi_m2s_wr_gen
    import axi_m2s_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    BURST_LEN  = 16,
    parameter int                    NUM_BURSTS = 4,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
    parameter logic [DATA_WIDTH-1:0] DATA_SEED  = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wlast,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready
);

    localparam int BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
    localparam int CNT_W       = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

    // Walks every burst of a run and reports whether any one straddles a 4 KB page.
    function automatic bit crosses_4k();
        longint off;
        for (int i = 0; i < NUM_BURSTS; i++) begin
            off = (longint'(START_ADDR[11:0]) + longint'(i) * BURST_BYTES) % 4096;
            if (off + BURST_BYTES > 4096) return 1'b1;
        end
        return 1'b0;
    endfunction

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_dw
            $error("axi_m2s_wr_gen: DATA_WIDTH must be 32 or 64");
        end
        if (BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_len
            $error("axi_m2s_wr_gen: BURST_LEN must be 1..256");
        end
        if (NUM_BURSTS < 1) begin : g_bad_num
            $error("axi_m2s_wr_gen: NUM_BURSTS must be >= 1");
        end
        if ((START_ADDR % ADDR_WIDTH'(BURST_BYTES)) != '0) begin : g_bad_align
            $error("axi_m2s_wr_gen: START_ADDR not aligned to burst size");
        end
        if (crosses_4k()) begin : g_bad_4k
            $error("axi_m2s_wr_gen: a burst would cross a 4 KB boundary");
        end
    endgenerate

    wr_state_e        state, state_nxt;
    logic [7:0]       beat_cnt;
    logic [CNT_W-1:0] burst_cnt;
    logic             last_beat, last_burst;

    assign last_beat  = (beat_cnt == 8'(BURST_LEN - 1));
    assign last_burst = (burst_cnt == CNT_W'(NUM_BURSTS - 1));

    assign m_awlen   = 8'(BURST_LEN - 1);
    assign m_awsize  = 3'($clog2(DATA_WIDTH / 8));
    assign m_awburst = BURST_INCR;
    assign m_wstrb   = '1;
    assign m_wlast   = last_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (start)                  state_nxt = ST_AW;
            ST_AW:   if (m_awready)              state_nxt = ST_W;
            ST_W:    if (m_wready && last_beat)  state_nxt = ST_B;
            ST_B:    if (m_bvalid)               state_nxt = last_burst ? ST_DONE : ST_AW;
            ST_DONE:                             state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    // Valids decode straight from registered state, so none depends on a ready.
    always_comb begin
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            ST_AW:   begin m_awvalid = 1'b1; busy = 1'b1; end
            ST_W:    begin m_wvalid  = 1'b1; busy = 1'b1; end
            ST_B:    begin m_bready  = 1'b1; busy = 1'b1; end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_awaddr  <= START_ADDR;
            m_wdata   <= DATA_SEED;
            beat_cnt  <= '0;
            burst_cnt <= '0;
            err       <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: if (start) begin
                    m_awaddr  <= START_ADDR;
                    m_wdata   <= DATA_SEED;
                    beat_cnt  <= '0;
                    burst_cnt <= '0;
                    err       <= 1'b0;
                end
                ST_W: if (m_wready) begin
                    m_wdata  <= m_wdata + 1'b1;
                    beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
                end
                ST_B: if (m_bvalid) begin
                    if (m_bresp != RESP_OKAY) err <= 1'b1;
                    if (!last_burst) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        m_awaddr  <= m_awaddr + ADDR_WIDTH'(BURST_BYTES);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_m2s_wr_gen.sv
// Scoreboard bench for axi_m2s_wr_gen: default config plus a single-beat, wrapping-seed config.
module tb_axi_m2s_wr_gen;
    import axi_m2s_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // default-configuration DUT
    logic        start, busy, done, err;
    logic [31:0] awaddr, wdata;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst, bresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    axi_m2s_wr_gen u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .m_awaddr(awaddr), .m_awlen(awlen), .m_awsize(awsize), .m_awburst(awburst),
        .m_awvalid(awvalid), .m_awready(awready), .m_wdata(wdata), .m_wstrb(wstrb),
        .m_wlast(wlast), .m_wvalid(wvalid), .m_wready(wready), .m_bresp(bresp),
        .m_bvalid(bvalid), .m_bready(bready)
    );

    // single-beat DUT with a seed that wraps on the second beat
    logic        s_start, s_busy, s_done, s_err;
    logic [31:0] s_awaddr, s_wdata;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst, s_bresp;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;

    axi_m2s_wr_gen #(.BURST_LEN(1), .NUM_BURSTS(3), .DATA_SEED(32'hFFFF_FFFF)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .busy(s_busy), .done(s_done), .err(s_err),
        .m_awaddr(s_awaddr), .m_awlen(s_awlen), .m_awsize(s_awsize), .m_awburst(s_awburst),
        .m_awvalid(s_awvalid), .m_awready(s_awready), .m_wdata(s_wdata), .m_wstrb(s_wstrb),
        .m_wlast(s_wlast), .m_wvalid(s_wvalid), .m_wready(s_wready), .m_bresp(s_bresp),
        .m_bvalid(s_bvalid), .m_bready(s_bready)
    );

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic unexpected(input string name);
        n_chk++;
        $display("FAIL %s: unexpected event (t=%0t)", name, $time);
    endtask

    typedef struct { logic [31:0] data; logic last; } wbeat_t;
    typedef struct { logic err; int lat; } done_t;

    logic [31:0] exp_aw[$];
    wbeat_t      exp_w[$];
    logic        exp_berr[$];
    done_t       exp_done[$];
    logic [31:0] s_exp_aw[$];
    wbeat_t      s_exp_w[$];

    int  start_cyc;
    int  done_cnt = 0, s_done_cnt = 0;
    bit  stall_mode = 1'b0;
    int  slverr_burst = -1;

    // Hand-computed run for the default config: 4 x 16 beats, 64 B apart, data 0..63.
    logic [31:0] aw_tbl [4] = '{32'h000, 32'h040, 32'h080, 32'h0C0};

    task automatic push_run(input int bad_burst, input int lat);
        done_t d;
        for (int b = 0; b < 4; b++) begin
            exp_aw.push_back(aw_tbl[b]);
            exp_berr.push_back(bad_burst >= 0 && b >= bad_burst);
            for (int i = 0; i < 16; i++) begin
                wbeat_t w;
                w.data = 32'(b * 16 + i);
                w.last = (i == 15);
                exp_w.push_back(w);
            end
        end
        d.err = (bad_burst >= 0);
        d.lat = lat;
        exp_done.push_back(d);
    endtask

    // Slave for the default DUT: optional random ready stalls, one B per W burst.
    initial begin
        int bidx;
        bit wl_hs, b_hs;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = RESP_OKAY; bidx = 0;
        forever begin
            @(negedge clk);
            wl_hs = wvalid && wready && wlast;
            b_hs  = bvalid && bready;
            if (start) bidx = 0;
            @(posedge clk); #1;
            if (!rst_n) begin
                bvalid = 1'b0;
                bidx   = 0;
            end else begin
                if (b_hs) bvalid = 1'b0;
                if (wl_hs) begin
                    bvalid = 1'b1;
                    bresp  = (bidx == slverr_burst) ? RESP_SLVERR : RESP_OKAY;
                    bidx++;
                end
            end
            awready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            wready  = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor for the default DUT.
    initial begin
        logic p_aw, p_w, p_last, b_pend;
        logic [31:0] p_addr, p_data;
        done_t d;
        p_aw = 0; p_w = 0; b_pend = 0; p_last = 0; p_addr = 0; p_data = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_aw = 0; p_w = 0; b_pend = 0;
                continue;
            end
            if (b_pend) begin
                if (exp_berr.size() == 0) unexpected("b_resp");
                else check("err_after_b", err, exp_berr.pop_front());
                b_pend = 0;
            end
            if (p_aw) check("aw_hold", {awvalid, awaddr}, {1'b1, p_addr});
            if (p_w)  check("w_hold", {wvalid, wlast, wdata}, {1'b1, p_last, p_data});
            if (awvalid && wvalid) unexpected("aw_w_overlap");
            if (awvalid && awready) begin
                if (exp_aw.size() == 0) unexpected("aw_hs");
                else check("awaddr", awaddr, exp_aw.pop_front());
                check("aw_ctrl", {awlen, awsize, awburst}, {8'd15, 3'd2, 2'b01});
            end
            if (wvalid && wready) begin
                wbeat_t w;
                if (exp_w.size() == 0) unexpected("w_hs");
                else begin
                    w = exp_w.pop_front();
                    check("wdata", wdata, w.data);
                    check("wlast", wlast, w.last);
                end
                check("wstrb", wstrb, 4'hF);
            end
            if (bvalid && bready) b_pend = 1;
            if (done) begin
                if (exp_done.size() == 0) unexpected("done");
                else begin
                    d = exp_done.pop_front();
                    check("err_at_done", err, d.err);
                    // cycles counted inclusively from the start cycle to the done cycle
                    if (d.lat > 0) check("done_latency", cyc - start_cyc + 1, d.lat);
                end
                done_cnt++;
            end
            p_aw = awvalid && !awready; p_addr = awaddr;
            p_w  = wvalid && !wready;   p_data = wdata; p_last = wlast;
        end
    end

    // Slave for the single-beat DUT: always ready, OKAY responses.
    initial begin
        bit wl_hs, b_hs;
        s_awready = 1'b1; s_wready = 1'b1; s_bvalid = 1'b0; s_bresp = RESP_OKAY;
        forever begin
            @(negedge clk);
            wl_hs = s_wvalid && s_wready && s_wlast;
            b_hs  = s_bvalid && s_bready;
            @(posedge clk); #1;
            if (!rst_n) s_bvalid = 1'b0;
            else begin
                if (b_hs)  s_bvalid = 1'b0;
                if (wl_hs) s_bvalid = 1'b1;
            end
        end
    end

    // Monitor for the single-beat DUT.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (s_awvalid && s_awready) begin
                if (s_exp_aw.size() == 0) unexpected("s_aw_hs");
                else check("s_awaddr", s_awaddr, s_exp_aw.pop_front());
                check("s_aw_ctrl", {s_awlen, s_awsize, s_awburst}, {8'd0, 3'd2, 2'b01});
            end
            if (s_wvalid && s_wready) begin
                wbeat_t w;
                if (s_exp_w.size() == 0) unexpected("s_w_hs");
                else begin
                    w = s_exp_w.pop_front();
                    check("s_wdata", s_wdata, w.data);
                    check("s_wlast", s_wlast, w.last);
                end
            end
            if (s_done) begin
                check("s_err_at_done", s_err, 1'b0);
                s_done_cnt++;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);
        check("err_cleared_on_start", err, 1'b0);
    endtask

    task automatic wait_done(input int budget);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk);
            if (done_cnt != d0) seen = 1;
        end
        if (!seen) unexpected("done_timeout");
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("busy_after_done", busy, 1'b0);
        check("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        wbeat_t w;
        start = 1'b0;
        s_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {busy, done, err, awvalid, wvalid, bready}, 6'b0);
        check("rst_awaddr", awaddr, 32'h0);
        check("rst_wdata", wdata, 32'h0);
        check("rst_s_wdata", s_wdata, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // back-to-back ready, OKAY responses
        push_run(-1, 74);
        pulse_start();
        wait_done(300);
        check("aw_drained", exp_aw.size(), 0);
        check("w_drained", exp_w.size(), 0);

        // random ready stalls on AW and W
        stall_mode = 1'b1;
        push_run(-1, 0);
        pulse_start();
        wait_done(3000);
        stall_mode = 1'b0;
        check("stall_w_drained", exp_w.size(), 0);

        // SLVERR on burst index 2 sticks to the end of the run, next start clears it
        slverr_burst = 2;
        push_run(2, 0);
        pulse_start();
        wait_done(300);
        check("err_sticky", err, 1'b1);
        slverr_burst = -1;
        push_run(-1, 74);
        pulse_start();
        wait_done(300);

        // asynchronous reset on beat 7 of burst 1
        push_run(-1, 0);
        pulse_start();
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (wvalid && wdata == 32'd23) seen = 1;
        end
        if (!seen) unexpected("beat23_timeout");
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctrl", {busy, done, err, awvalid, wvalid, bready}, 6'b0);
        check("arst_awaddr", awaddr, 32'h0);
        check("arst_wdata", wdata, 32'h0);
        exp_aw.delete(); exp_w.delete(); exp_berr.delete(); exp_done.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        push_run(-1, 74);
        pulse_start();
        wait_done(300);

        // single-beat bursts, seed wraps through zero
        s_exp_aw.push_back(32'h0); s_exp_aw.push_back(32'h4); s_exp_aw.push_back(32'h8);
        w.last = 1'b1;
        w.data = 32'hFFFF_FFFF; s_exp_w.push_back(w);
        w.data = 32'h0000_0000; s_exp_w.push_back(w);
        w.data = 32'h0000_0001; s_exp_w.push_back(w);
        @(posedge clk); #1 s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        check("s_busy_after_start", s_busy, 1'b1);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            if (s_done_cnt != 0) seen = 1;
        end
        if (!seen) unexpected("s_done_timeout");
        check("s_done_count", s_done_cnt, 1);
        check("s_w_drained", s_exp_w.size(), 0);
        check("s_aw_drained", s_exp_aw.size(), 0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
